// File: rtl/ser_link_tx_sched.sv
// ser_link_tx_sched: schedules flits from NUM_VCS virtual channels onto one
// credit-controlled serial link. A round-robin arbiter grants one eligible VC
// (valid, credit available, link up). The flit goes out as a header beat
// carrying the VC id, followed by FLIT_W/SER_W data beats, LSB nibble first.
//
// Ports
//   CLK, RST_N   clock (rising edge), async active-low reset
//   vc_valid     per-VC flit available
//   vc_flit      per-VC flit, VC i at [i*FLIT_W +: FLIT_W]
//   vc_deq       one-hot dequeue pulse in the grant cycle
//   credit_ret   far end returned one credit for VC credit_vc
//   credit_vc    VC of the returned credit
//   link_up      serial link synchronised; gates new grants only
//   ser_out      serial lane data
//   ser_frame    high on header and data beats
//   busy         a frame is in flight
//   credit_cnt   per-VC credit counters, VC i at [i*CW +: CW]
//   credit_ovf   sticky: credit return beyond CREDITS or to a bad VC
module ser_link_tx_sched #(
  parameter int NUM_VCS = 2,
  parameter int FLIT_W  = 32,
  parameter int SER_W   = 4,
  parameter int CREDITS = 4,
  localparam int BEATS  = FLIT_W / SER_W,
  localparam int CW     = $clog2(CREDITS + 1),
  localparam int VW     = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
  localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic [NUM_VCS-1:0]        vc_valid,
  input  logic [NUM_VCS*FLIT_W-1:0] vc_flit,
  output logic [NUM_VCS-1:0]        vc_deq,
  input  logic                      credit_ret,
  input  logic [VW-1:0]             credit_vc,
  input  logic                      link_up,
  output logic [SER_W-1:0]          ser_out,
  output logic                      ser_frame,
  output logic                      busy,
  output logic [NUM_VCS*CW-1:0]     credit_cnt,
  output logic                      credit_ovf
);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA} state_t;

  state_t                       r_state;
  logic [VW-1:0]                r_last;
  logic [FLIT_W-1:0]            r_flit;
  logic [BW-1:0]                r_beat;
  logic [NUM_VCS-1:0][CW-1:0]   r_credit;
  logic                         r_ovf;
  logic                         r_frame;
  logic                         r_busy;
  logic [SER_W-1:0]             r_ser;

  logic [NUM_VCS-1:0]           w_elig;
  logic                         w_found;
  logic [VW-1:0]                w_gnt;
  logic                         w_grant;
  logic [FLIT_W-1:0]            w_sel_flit;
  logic [NUM_VCS-1:0]           w_inc;
  logic [NUM_VCS-1:0]           w_dec;
  logic                         w_ovf;

  // Eligibility uses registered credits, so a credit returned this cycle
  // only counts from the next cycle on.
  always_comb begin
    for (int i = 0; i < NUM_VCS; i++)
      w_elig[i] = vc_valid[i] & (r_credit[i] != '0) & link_up;
  end

  // Round-robin: search starts just after the last granted VC.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    for (int k = 1; k <= NUM_VCS; k++) begin
      if (!w_found && w_elig[(int'(r_last) + k) % NUM_VCS]) begin
        w_found = 1'b1;
        w_gnt   = VW'((int'(r_last) + k) % NUM_VCS);
      end
    end
  end

  // RST_N gating keeps the combinational dequeue quiet while held in reset.
  assign w_grant    = (r_state == S_IDLE) & w_found & RST_N;
  assign w_sel_flit = vc_flit[int'(w_gnt)*FLIT_W +: FLIT_W];

  always_comb begin
    vc_deq = '0;
    if (w_grant) vc_deq[w_gnt] = 1'b1;
  end

  // Return and grant on the same VC cancel; a return at a full counter is
  // dropped and flagged.
  always_comb begin
    w_ovf = credit_ret & (int'(credit_vc) >= NUM_VCS);
    for (int i = 0; i < NUM_VCS; i++) begin
      w_inc[i] = credit_ret & (int'(credit_vc) == i);
      w_dec[i] = w_grant & (int'(w_gnt) == i);
      if (w_inc[i] && !w_dec[i] && r_credit[i] == CW'(CREDITS)) w_ovf = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_ovf <= 1'b0;
      for (int i = 0; i < NUM_VCS; i++) r_credit[i] <= CW'(CREDITS);
    end else begin
      if (w_ovf) r_ovf <= 1'b1;
      for (int i = 0; i < NUM_VCS; i++) begin
        if (w_inc[i] && !w_dec[i] && r_credit[i] != CW'(CREDITS))
          r_credit[i] <= r_credit[i] + CW'(1);
        else if (w_dec[i] && !w_inc[i])
          r_credit[i] <= r_credit[i] - CW'(1);
      end
    end
  end

  // Outputs are registered one cycle ahead of the state they belong to, so
  // the grant edge already loads the header beat. The flit is shifted right
  // so the next beat is always in the low SER_W bits.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_last  <= VW'(NUM_VCS - 1);
      r_flit  <= '0;
      r_beat  <= '0;
      r_ser   <= '0;
      r_frame <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_state <= S_HDR;
            r_last  <= w_gnt;
            r_flit  <= w_sel_flit;
            r_ser   <= SER_W'(w_gnt);
            r_frame <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_HDR: begin
          r_state <= S_DATA;
          r_beat  <= '0;
          r_ser   <= r_flit[SER_W-1:0];
          r_flit  <= r_flit >> SER_W;
        end
        S_DATA: begin
          if (r_beat == BW'(BEATS - 1)) begin
            r_state <= S_IDLE;
            r_ser   <= '0;
            r_frame <= 1'b0;
            r_busy  <= 1'b0;
          end else begin
            r_beat  <= r_beat + BW'(1);
            r_ser   <= r_flit[SER_W-1:0];
            r_flit  <= r_flit >> SER_W;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ser_out    = r_ser;
  assign ser_frame  = r_frame;
  assign busy       = r_busy;
  assign credit_cnt = r_credit;
  assign credit_ovf = r_ovf;

endmodule

// File: tb/tb_ser_link_tx_sched.sv
module tb_ser_link_tx_sched;
  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [1:0]  vc_valid = '0;
  logic [63:0] vc_flit;
  logic [1:0]  vc_deq;
  logic        credit_ret = 1'b0;
  logic [0:0]  credit_vc = '0;
  logic        link_up = 1'b1;
  logic [3:0]  ser_out;
  logic        ser_frame, busy, credit_ovf;
  logic [5:0]  credit_cnt;

  logic [31:0] fl0 = 32'h0, fl1 = 32'h0;
  assign vc_flit = {fl1, fl0};

  int n_cmp = 0, n_err = 0, cyc = 0, gcyc = 0;
  logic [3:0] q_exp[$];

  ser_link_tx_sched dut (
    .CLK(CLK), .RST_N(RST_N), .vc_valid(vc_valid), .vc_flit(vc_flit),
    .vc_deq(vc_deq), .credit_ret(credit_ret), .credit_vc(credit_vc),
    .link_up(link_up), .ser_out(ser_out), .ser_frame(ser_frame), .busy(busy),
    .credit_cnt(credit_cnt), .credit_ovf(credit_ovf)
  );

  initial forever #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Beat scoreboard: every framed beat must match the next expected nibble.
  always @(negedge CLK) begin
    if (RST_N) begin
      if (ser_frame) begin
        if (q_exp.size() == 0) chk("extra_beat", ser_out, 4'hx);
        else chk("beat", ser_out, q_exp.pop_front());
      end else begin
        chk("idle_out", ser_out, 0);
      end
    end
  end

  task automatic push_frame(input int vc, input logic [31:0] f);
    q_exp.push_back(4'(vc));
    for (int k = 0; k < 8; k++) q_exp.push_back(f[k*4 +: 4]);
  endtask

  task automatic do_reset();
    RST_N = 1'b0; vc_valid = '0; credit_ret = 1'b0; credit_vc = '0; link_up = 1'b1;
    q_exp.delete();
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_ser_out", ser_out, 0);
    chk("rst_frame", ser_frame, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", credit_ovf, 0);
    chk("rst_credits", credit_cnt, 6'b100_100);
    vc_valid = 2'b11;
    #1 chk("rst_deq", vc_deq, 0);
    vc_valid = '0;
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic wait_deq(input int maxc, output logic got);
    got = 1'b0;
    for (int i = 0; i < maxc && !got; i++) begin
      @(negedge CLK);
      if (vc_deq != 0) got = 1'b1;
    end
    if (!got) chk("deq_timeout", 0, 1);
  endtask

  task automatic grant_step(input int vc, input string tag);
    logic got;
    wait_deq(30, got);
    if (got) begin
      chk(tag, vc_deq, 2'b01 << vc);
      push_frame(vc, (vc == 1) ? fl1 : fl0);
      gcyc = cyc;
    end
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 30 && busy; i++) @(negedge CLK);
    if (busy) chk("idle_timeout", busy, 0);
  endtask

  task automatic count_deq(input int n, input string tag);
    int c = 0;
    repeat (n) begin
      @(negedge CLK);
      if (vc_deq != 0) c++;
    end
    chk(tag, c, 0);
  endtask

  initial begin
    int prev;
    do_reset();

    // Single flit, LSB nibble first; flit changed after grant must not leak.
    fl0 = 32'hDEADBEEF;
    @(posedge CLK); #1 vc_valid = 2'b01;
    grant_step(0, "single_deq");
    prev = gcyc;
    @(posedge CLK); #1 vc_valid = 2'b00; fl0 = 32'h12345678;
    @(negedge CLK);
    chk("hdr_frame", ser_frame, 1);
    chk("hdr_out", ser_out, 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      chk("data_frame", ser_frame, 1);
    end
    @(negedge CLK);
    chk("frame_end", ser_frame, 0);
    chk("frame_len", cyc - prev, 10);
    chk("single_credit0", credit_cnt[2:0], 3);

    // Fairness: both valid, alternate grants 10 cycles apart.
    do_reset();
    fl0 = 32'hA5A5_0F0F; fl1 = 32'h1357_9BDF;
    @(posedge CLK); #1 vc_valid = 2'b11;
    for (int n = 0; n < 4; n++) begin
      grant_step(n % 2, "rr_deq");
      if (n > 0) chk("rr_gap", gcyc - prev, 10);
      prev = gcyc;
      @(posedge CLK); #1;
      if (n % 2 == 1) fl1 = $urandom; else fl0 = $urandom;
    end
    vc_valid = 2'b00;
    wait_idle();
    chk("rr_credits", credit_cnt, 6'b010_010);

    // Credit starvation and the return-to-grant latency.
    do_reset();
    fl0 = 32'hCAFE_F00D;
    @(posedge CLK); #1 vc_valid = 2'b01;
    for (int n = 0; n < 4; n++) begin
      grant_step(0, "starve_deq");
      @(posedge CLK); #1 fl0 = $urandom;
    end
    count_deq(30, "starve_no_deq");
    chk("starve_credit0", credit_cnt[2:0], 0);
    @(posedge CLK); #1 credit_ret = 1'b1; credit_vc = 1'b0;
    @(negedge CLK);
    chk("ret_same_cycle_deq", vc_deq, 2'b00);
    @(posedge CLK); #1 credit_ret = 1'b0;
    @(negedge CLK);
    chk("ret_next_cycle_deq", vc_deq, 2'b01);
    if (vc_deq == 2'b01) push_frame(0, fl0);
    @(posedge CLK); #1 vc_valid = 2'b00;
    wait_idle();

    // Simultaneous grant/return on VC1 at credit 1, then overflow on VC0.
    do_reset();
    fl1 = 32'h0BAD_BEEF;
    @(posedge CLK); #1 vc_valid = 2'b10;
    for (int n = 0; n < 3; n++) begin
      grant_step(1, "sim_deq");
      @(posedge CLK); #1 fl1 = $urandom;
    end
    vc_valid = 2'b00;
    wait_idle();
    chk("sim_credit1_pre", credit_cnt[5:3], 1);
    @(posedge CLK); #1 vc_valid = 2'b10; credit_ret = 1'b1; credit_vc = 1'b1;
    @(negedge CLK);
    chk("sim_grant", vc_deq, 2'b10);
    if (vc_deq == 2'b10) push_frame(1, fl1);
    @(posedge CLK); #1 vc_valid = 2'b00; credit_ret = 1'b0;
    @(negedge CLK);
    chk("sim_credit1", credit_cnt[5:3], 1);
    chk("sim_no_ovf", credit_ovf, 0);
    @(posedge CLK); #1 credit_ret = 1'b1; credit_vc = 1'b0;
    @(posedge CLK); #1 credit_ret = 1'b0;
    @(negedge CLK);
    chk("ovf_credit0", credit_cnt[2:0], 4);
    chk("ovf_flag", credit_ovf, 1);
    wait_idle();
    chk("ovf_sticky", credit_ovf, 1);

    // Link drop: no grants while down, frame in flight completes.
    do_reset();
    fl0 = 32'h8765_4321;
    @(posedge CLK); #1 link_up = 1'b0; vc_valid = 2'b01;
    count_deq(5, "link_down_no_deq");
    @(posedge CLK); #1 link_up = 1'b1;
    grant_step(0, "link_deq");
    @(posedge CLK); #1 link_up = 1'b0;
    wait_idle();
    count_deq(5, "link_down_no_deq2");
    vc_valid = 2'b00; link_up = 1'b1;
    chk("link_q_drained", q_exp.size(), 0);

    // Abort: reset during DATA beat 3 clears outputs without a clock edge.
    do_reset();
    fl0 = 32'hFEED_FACE;
    @(posedge CLK); #1 vc_valid = 2'b01;
    grant_step(0, "abort_deq");
    @(posedge CLK); #1 vc_valid = 2'b00;
    repeat (4) @(posedge CLK);
    #2;
    chk("abort_pre_frame", ser_frame, 1);
    RST_N = 1'b0;
    #1;
    chk("abort_frame", ser_frame, 0);
    chk("abort_out", ser_out, 0);
    chk("abort_busy", busy, 0);
    chk("abort_credits", credit_cnt, 6'b100_100);
    do_reset();
    count_deq(12, "post_abort_no_deq");

    chk("q_empty", q_exp.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ser_link_tx_sched.md
SER_LINK_TX_SCHED -- requirements
Module: ser_link_tx_sched

Interface
REQ-001 SHALL have parameter NUM_VCS, 2: virtual channels sharing one inter-FPGA serial link.
REQ-002 SHALL have parameter FLIT_W, 32: flit width; a multiple of SER_W.
REQ-003 SHALL have parameter SER_W, 4: serial lane width; BEATS = FLIT_W/SER_W.
REQ-004 SHALL have parameter CREDITS, 4: far-end buffer depth per VC; CW = clog2(CREDITS+1).
REQ-005 SHALL have port CLK  in  1: single clock; all logic on its rising edge.
REQ-006 SHALL have port RST_N  in  1: reset, asynchronous, active-low.
REQ-007 SHALL have port vc_valid  in  NUM_VCS: flit available per VC.
REQ-008 SHALL have port vc_flit  in  NUM_VCS*FLIT_W: per-VC flit; VC i at bits [i*FLIT_W +: FLIT_W].
REQ-009 SHALL have port vc_deq  out  NUM_VCS: one-hot dequeue pulse to the granted VC.
REQ-010 SHALL have port credit_ret  in  1: far end frees one slot, one credit per cycle.
REQ-011 SHALL have port credit_vc  in  clog2(NUM_VCS): VC of the returned credit.
REQ-012 SHALL have port link_up  in  1: serial link synchronised.
REQ-013 SHALL have port ser_out  out  SER_W: serial lane data.
REQ-014 SHALL have port ser_frame  out  1: high on every header and data beat.
REQ-015 SHALL have port busy  out  1: FSM is not in IDLE.
REQ-016 SHALL have port credit_cnt  out  NUM_VCS*CW: per-VC credit counters.
REQ-017 SHALL have port credit_ovf  out  1: sticky credit-overflow error.

Function
REQ-018 SHALL implement FSM IDLE -> HDR -> DATA -> IDLE.
REQ-019 In IDLE, eligible[i] SHALL be vc_valid[i] & (credit[i] > 0) & link_up.
REQ-020 In IDLE with any eligible VC, SHALL grant one VC:
- round-robin search starting at (last_grant+1) mod NUM_VCS, wrapping;
- last_grant resets to NUM_VCS-1.
REQ-021 On the grant cycle, SHALL:
- pulse vc_deq[g] for exactly one cycle;
- latch vc_flit[g] and g;
- decrement credit[g];
- move to HDR.
REQ-022 HDR SHALL last one cycle: ser_frame=1, ser_out = g zero-extended.
REQ-023 DATA SHALL last BEATS cycles: ser_frame=1, beat k drives latched flit bits [k*SER_W +: SER_W], LSB nibble first.
REQ-024 After the last DATA beat, SHALL return to IDLE; frames are BEATS+1 link cycles followed by at least one idle cycle.
REQ-025 Outside HDR and DATA, SHALL drive ser_out=0 and ser_frame=0; vc_deq SHALL be 0 outside grant cycles.
REQ-026 credit_ret SHALL increment credit[credit_vc] at the next edge.
REQ-027 A return and a grant on the same VC in the same cycle SHALL leave that counter unchanged.
REQ-028 A return to a counter already at CREDITS SHALL leave it at CREDITS and set credit_ovf until reset.
REQ-029 A credit_vc value >= NUM_VCS SHALL be ignored and set credit_ovf.
REQ-030 link_up falling mid-frame SHALL NOT abort the frame; no new grant SHALL occur while link_up=0.
REQ-031 A credit returned in cycle t SHALL make that VC eligible for a grant no earlier than cycle t+1.
REQ-032 vc_flit changes after the grant cycle SHALL NOT affect the frame in flight.

Reset
REQ-033 RST_N low SHALL, asynchronously:
- force state IDLE, ser_out=0, ser_frame=0, vc_deq=0, busy=0, credit_ovf=0;
- set every credit to CREDITS and last_grant to NUM_VCS-1.
REQ-034 Reset mid-frame SHALL drop the frame with no further beats; the first grant SHALL occur no earlier than the first edge after RST_N rises.

Verification (NUM_VCS=2, FLIT_W=32, SER_W=4, CREDITS=4)
REQ-035 Reset: RST_N low for 3 cycles -> all outputs 0, credit_cnt = {4,4}.
REQ-036 Single flit: VC0 valid, flit 0xDEADBEEF, grant at t -> vc_deq=01 at t; HDR ser_out=0 at t+1; beats F,E,E,B,D,A,E,D at t+2..t+9; ser_frame=0 at t+10.
REQ-037 Fairness: both VCs continuously valid with ample credit -> grants VC0,VC1,VC0,VC1, consecutive grants 10 cycles apart.
REQ-038 Credit starvation: VC0 always valid, no returns -> exactly 4 frames then stall with credit_cnt[0]=0; one credit_ret for VC0 at t -> grant at t+1.
REQ-039 Simultaneous: credit[1]=1, grant VC1 and credit_ret VC1 in the same cycle -> credit[1] stays 1; a return at credit 4 -> stays 4 and credit_ovf=1.
REQ-040 Abort: RST_N dropped during DATA beat 3 -> ser_frame=0 and ser_out=0 without waiting for CLK; credits restored to 4.
